seg_scan_display: RTL and testbench

Parametrised successor to the fixed 8-digit segment path. It converts one binary value into N_DIGITS display digits, using sequential double-dabble for decimal or direct nibbles for hex. It then time-multiplexes the digits onto a single shared seven-segment bus, with leading-zero blanking and overflow indication. It sits between the row-count logic (for example, cnt_row) and the board display pins, and gives one-hot digit scanning in place of eight static decoders.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_scan_display_if.sv | 26 ++
 rtl/seg_bin2bcd.sv | 52 +++++
 rtl/seg_scan_display.sv | 93 +++++++++
 tb/tb_seg_scan_display.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns, FSM state type and nibble encoder
// Patterns are {g,f,e,d,c,b,a}, active-high, before any output polarity step.
package seg_pkg;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_LUT [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: load/status/display bundle of the scanned segment driver
// master drives value_in, load, mode_hex, blank_lz; slave drives busy, overflow,
// digit_sel and seg_data.
interface seg_scan_display_if #(
    parameter int N_DIGITS = 8,
    parameter int VAL_W    = 10
);
    logic [VAL_W-1:0]    value_in;
    logic                load;
    logic                mode_hex;
    logic                blank_lz;
    logic                busy;
    logic                overflow;
    logic [N_DIGITS-1:0] digit_sel;
    logic [6:0]          seg_data;

    modport master (
        output value_in, load, mode_hex, blank_lz,
        input  busy, overflow, digit_sel, seg_data
    );

    modport slave (
        input  value_in, load, mode_hex, blank_lz,
        output busy, overflow, digit_sel, seg_data
    );
endinterface

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: sequential double-dabble converter, one input bit per cycle
// Ports: clk, rstb (sync active-high), start (loads value), value,
// done (high in the cycle performing the last shift), bcd, ovf (sticky).
module seg_bin2bcd #(
    parameter int VAL_W    = 10,
    parameter int N_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    start,
    input  logic [VAL_W-1:0]        value,
    output logic                    done,
    output logic [4*N_DIGITS-1:0]   bcd,
    output logic                    ovf
);
    localparam int NW = 4 * N_DIGITS;
    localparam int CW = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    sh;
    logic [CW-1:0]       cnt;
    logic [NW-1:0]       adj;
    logic [NW+VAL_W-1:0] nxt;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < N_DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Whatever leaves the top nibble is a carry the display cannot hold.
    assign nxt  = {adj, sh} << 1;
    assign done = cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (rstb) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (start) begin
            sh  <= value;
            bcd <= '0;
            cnt <= CW'(VAL_W);
            ovf <= 1'b0;
        end else if (cnt != '0) begin
            sh  <= nxt[VAL_W-1:0];
            bcd <= nxt[NW+VAL_W-1:VAL_W];
            ovf <= ovf | adj[NW-1];
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: binary value to multiplexed seven-segment display driver
// Ports: clk, rstb (sync active-high reset), bus (slave side of
// seg_scan_display_if: value_in/load/mode_hex/blank_lz in,
// busy/overflow/digit_sel/seg_data out).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int VAL_W          = 10,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rstb,
    seg_scan_display_if.slave bus
);
    localparam int NW = 4 * N_DIGITS;
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [IW-1:0]       LAST    = IW'(N_DIGITS - 1);
    localparam logic [PW-1:0]       PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [N_DIGITS-1:0] ONE     = N_DIGITS'(1);

    state_t              state;
    logic                busy_q, ovf_q, hex_q, start, done, eng_ovf, lz;
    logic [VAL_W-1:0]    val_q;
    logic [NW-1:0]       nib, bcd;
    logic [VAL_W+NW-1:0] ext;
    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [N_DIGITS-1:0] dig_q;
    logic [6:0]          seg_q;

    assign start = state == IDLE && bus.load && !bus.mode_hex;
    // Upper part of ext holds any value bits that do not fit the hex display.
    assign ext   = {{NW{1'b0}}, val_q};

    seg_bin2bcd #(.VAL_W(VAL_W), .N_DIGITS(N_DIGITS)) u_bin2bcd (
        .clk   (clk),
        .rstb  (rstb),
        .start (start),
        .value (bus.value_in),
        .done  (done),
        .bcd   (bcd),
        .ovf   (eng_ovf)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            hex_q  <= 1'b0;
            val_q  <= '0;
            nib    <= '0;
        end else if (state == IDLE && bus.load) begin
            val_q  <= bus.value_in;
            hex_q  <= bus.mode_hex;
            busy_q <= 1'b1;
            state  <= bus.mode_hex ? COMMIT : CONV;
        end else if (state == CONV && done) begin
            state  <= COMMIT;
        end else if (state == COMMIT) begin
            nib    <= hex_q ? ext[NW-1:0] : bcd;
            ovf_q  <= hex_q ? |ext[VAL_W+NW-1:NW] : eng_ovf;
            busy_q <= 1'b0;
            state  <= IDLE;
        end
    end

    // A digit is a leading zero when it and every higher nibble are zero.
    assign lz = bus.blank_lz && idx != '0 && (nib >> (4 * idx)) == '0;

    always_ff @(posedge clk) begin
        if (rstb) begin
            pre   <= '0;
            idx   <= '0;
            dig_q <= '0;
            seg_q <= SEG_BLANK;
        end else begin
            pre   <= pre == PRE_MAX ? '0 : pre + 1'b1;
            idx   <= pre == PRE_MAX ? (idx == LAST ? '0 : idx + 1'b1) : idx;
            dig_q <= ONE << idx;
            seg_q <= ovf_q ? SEG_DASH : lz ? SEG_BLANK : seg_encode(nib[4*idx +: 4]);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.overflow  = ovf_q;
    assign bus.digit_sel = DIG_ACTIVE_LOW != 0 ? ~dig_q : dig_q;
    assign bus.seg_data  = SEG_ACTIVE_LOW != 0 ? ~seg_q : seg_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: scoreboard bench for two display widths driven in parallel
module tb_seg_scan_display;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       ld = 1'b0;
    logic       hx = 1'b0;
    logic       blz = 1'b0;
    logic [9:0] val = '0;

    always #5 clk = ~clk;

    seg_scan_display_if #(.N_DIGITS(8), .VAL_W(10)) b0 ();
    seg_scan_display_if #(.N_DIGITS(2), .VAL_W(10)) b1 ();

    assign b0.value_in = val;
    assign b0.load     = ld;
    assign b0.mode_hex = hx;
    assign b0.blank_lz = blz;
    assign b1.value_in = val;
    assign b1.load     = ld;
    assign b1.mode_hex = hx;
    assign b1.blank_lz = blz;

    seg_scan_display #(.N_DIGITS(8), .VAL_W(10), .CLK_DIV(CLK_DIV),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut0 (
        .clk(clk), .rstb(rstb), .bus(b0));
    seg_scan_display #(.N_DIGITS(2), .VAL_W(10), .CLK_DIV(CLK_DIV),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .bus(b1));

    logic       bsy [2];
    logic       ovf [2];
    logic [7:0] dsel [2];
    logic [6:0] seg [2];

    assign bsy[0]  = b0.busy;
    assign bsy[1]  = b1.busy;
    assign ovf[0]  = b0.overflow;
    assign ovf[1]  = b1.overflow;
    assign dsel[0] = b0.digit_sel;
    assign dsel[1] = {6'b0, b1.digit_sel};
    assign seg[0]  = b0.seg_data;
    assign seg[1]  = b1.seg_data;

    typedef struct {
        logic [9:0] v;
        bit         h;
        int         len;
    } entry_t;

    entry_t q [2][$];

    localparam logic [6:0] SEG_T [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_chk = 0;
    int n_fail = 0;

    function automatic int lane_n(int l);
        return l == 0 ? 8 : 2;
    endfunction

    function automatic longint pw(int base, int e);
        longint r = 1;
        repeat (e) r = r * base;
        return r;
    endfunction

    // Reference: a value overflows when it is not below base**digits.
    function automatic bit m_ovf(int n, logic [9:0] v, bit h);
        return longint'(v) >= pw(h ? 16 : 10, n);
    endfunction

    function automatic logic [6:0] m_pat(int n, logic [9:0] v, bit h, bit blank, int k);
        int     base = h ? 16 : 10;
        longint p    = pw(base, k);
        if (m_ovf(n, v, h)) return 7'h40;
        if (blank && k > 0 && longint'(v) / p == 0) return 7'h00;
        return SEG_T[int'((longint'(v) / p) % base)];
    endfunction

    task automatic chk(string nm, int l, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d: got %h, want %h at %0t", nm, l, act, exp, $time);
        end
    endtask

    logic rst_s = 1'b0;
    logic blz_s = 1'b0;

    always @(posedge clk) begin
        rst_s <= rstb;
        blz_s <= blz;
    end

    bit         started = 0;
    int         k = 0;
    logic [9:0] cur_v [2];
    bit         cur_h [2];
    int         bcnt [2];
    bit         prev_b [2];

    always @(negedge clk) begin
        int         n, idx;
        logic [6:0] e;
        entry_t     ent;
        if (rst_s) begin
            started = 1;
            k = 0;
            for (int l = 0; l < 2; l++) begin
                q[l].delete();
                cur_v[l]  = '0;
                cur_h[l]  = 0;
                bcnt[l]   = 0;
                prev_b[l] = 0;
                chk("rst_busy", l, 32'(bsy[l]), 32'd0);
                chk("rst_ovf", l, 32'(ovf[l]), 32'd0);
                chk("rst_dsel", l, 32'(dsel[l]), 32'((1 << lane_n(l)) - 1));
                chk("rst_seg", l, 32'(seg[l]), 32'h7F);
            end
        end else if (started) begin
            k++;
            for (int l = 0; l < 2; l++) begin
                n   = lane_n(l);
                idx = ((k - 1) / CLK_DIV) % n;
                e   = ~m_pat(n, cur_v[l], cur_h[l], blz_s, idx);
                chk("dsel", l, 32'(dsel[l]), 32'(((1 << n) - 1) & ~(1 << idx)));
                chk("seg", l, 32'(seg[l]), 32'(e));
                if (bsy[l]) begin
                    bcnt[l]++;
                end else if (prev_b[l]) begin
                    chk("commit_expected", l, 32'(q[l].size() > 0), 32'd1);
                    if (q[l].size() > 0) begin
                        ent = q[l].pop_front();
                        chk("busy_len", l, 32'(bcnt[l]), 32'(ent.len));
                        cur_v[l] = ent.v;
                        cur_h[l] = ent.h;
                    end
                    bcnt[l] = 0;
                end
                prev_b[l] = bsy[l];
                chk("ovf", l, 32'(ovf[l]), 32'(m_ovf(n, cur_v[l], cur_h[l])));
            end
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(logic [9:0] v, bit h);
        entry_t e;
        e.v   = v;
        e.h   = h;
        e.len = h ? 1 : 11;
        q[0].push_back(e);
        q[1].push_back(e);
        val = v;
        hx  = h;
        ld  = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    task automatic poke(logic [9:0] v);
        val = v;
        ld  = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    initial begin
        bit         h;
        logic [9:0] v;
        rstb = 1'b1;
        @(posedge clk);
        #1 ld = 1'b1;
        val = 10'd5;
        @(posedge clk);
        #1 ld = 1'b0;
        @(posedge clk);
        #1 rstb = 1'b0;
        blz = 1'b1;
        wait_cyc(8);
        do_load(10'd987, 0);
        wait_cyc(48);
        blz = 1'b0;
        do_load(10'h2AF, 1);
        wait_cyc(48);
        blz = 1'b1;
        do_load(10'd100, 0);
        wait_cyc(48);
        do_load(10'd99, 0);
        wait_cyc(48);
        do_load(10'd321, 0);
        wait_cyc(2);
        poke(10'd555);
        wait_cyc(48);
        do_load(10'd777, 0);
        wait_cyc(4);
        rstb = 1'b1;
        wait_cyc(1);
        rstb = 1'b0;
        wait_cyc(48);
        repeat (40) begin
            blz = 1'($urandom_range(0, 1));
            h   = 1'($urandom_range(0, 1));
            v   = 10'($urandom_range(0, 1023));
            do_load(v, h);
            if (!h && $urandom_range(0, 1) == 1) begin
                wait_cyc(3);
                poke(10'($urandom_range(0, 1023)));
            end
            wait_cyc(12 + $urandom_range(0, 40));
        end
        wait_cyc(2);
        for (int l = 0; l < 2; l++)
            chk("queue_empty", l, 32'(q[l].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
